// File: rtl/mult_div_ctrl_if.sv
// Handshake and result bus between the CPU control unit and the HI/LO multiply/divide sequencer.
// The is_unsigned request bit exists only when MULTDIV_UNSIGNED_EN is defined.
interface mult_div_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
`ifdef MULTDIV_UNSIGNED_EN
    logic             is_unsigned;
`endif
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [2:0]       state_out;

`ifdef MULTDIV_UNSIGNED_EN
    modport master (
        output start, op, a_in, b_in, is_unsigned,
        input  busy, done, div_zero, hi, lo, state_out
    );
    modport slave (
        input  start, op, a_in, b_in, is_unsigned,
        output busy, done, div_zero, hi, lo, state_out
    );
`else
    modport master (
        output start, op, a_in, b_in,
        input  busy, done, div_zero, hi, lo, state_out
    );
    modport slave (
        input  start, op, a_in, b_in,
        output busy, done, div_zero, hi, lo, state_out
    );
`endif
endinterface

// File: rtl/mult_div_ctrl.sv
// Iterative Booth radix-2 multiply / restoring divide sequencer owning the HI/LO pair.
// Optional macro MULTDIV_UNSIGNED_EN adds an is_unsigned request bit (multu/divu).
//
// state | meaning
// IDLE  | waiting for start; operands latched on start
// MULT  | one Booth step per cycle, WIDTH cycles
// DIV   | one restoring-divide step per cycle, WIDTH cycles
// FIX   | sign correction of quotient/remainder, writes HI/LO
// DONE  | done pulse, HI/LO valid
// DZERO | divide by zero: done + div_zero pulse, HI/LO untouched
module mult_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic           clock,
    input  logic           reset,
    mult_div_ctrl_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MULT  = 3'd1,
        DIV   = 3'd2,
        FIX   = 3'd3,
        DONE  = 3'd4,
        DZERO = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0]    count;
    logic [WIDTH:0]   acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic             q_m1;
    logic [WIDTH-1:0] opnd_b;
    logic             sign_a;
    logic             sign_b;
    logic             op_unsigned;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;

    logic             busy;
    logic             done;
    logic             div_zero;
    logic             start_unsigned;

`ifdef MULTDIV_UNSIGNED_EN
    assign start_unsigned = bus.is_unsigned;
`else
    assign start_unsigned = 1'b0;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        div_zero  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (!bus.op) begin
                        state_nxt = MULT;
                    end else if (bus.b_in == '0) begin
                        state_nxt = DZERO;
                    end else begin
                        state_nxt = DIV;
                    end
                end
            end
            MULT: begin
                busy = 1'b1;
                if (count == CW'(1)) begin
                    state_nxt = DONE;
                end
            end
            DIV: begin
                busy = 1'b1;
                if (count == CW'(1)) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            DZERO: begin
                done      = 1'b1;
                div_zero  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- operand magnitudes at start ----------------
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    always_comb begin
        mag_a = bus.a_in;
        mag_b = bus.b_in;
        if (!start_unsigned && bus.a_in[WIDTH-1]) begin
            mag_a = -bus.a_in;
        end
        if (!start_unsigned && bus.b_in[WIDTH-1]) begin
            mag_b = -bus.b_in;
        end
    end

    // ---------------- Booth / shift-add step ----------------
    // The accumulator carries one extra bit so that hi - B cannot overflow
    // when B = -2^(WIDTH-1), and holds the carry out of the unsigned add.
    logic [WIDTH:0]   b_ext;
    logic [WIDTH:0]   booth_sum;
    logic             shift_top;
    logic [WIDTH:0]   mult_hi_nxt;
    logic [WIDTH-1:0] mult_lo_nxt;

    always_comb begin
        b_ext     = op_unsigned ? {1'b0, opnd_b} : {opnd_b[WIDTH-1], opnd_b};
        booth_sum = acc_hi;
        if (op_unsigned) begin
            if (acc_lo[0]) begin
                booth_sum = acc_hi + b_ext;
            end
        end else begin
            case ({acc_lo[0], q_m1})
                2'b01:   booth_sum = acc_hi + b_ext;
                2'b10:   booth_sum = acc_hi - b_ext;
                default: booth_sum = acc_hi;
            endcase
        end
        shift_top   = op_unsigned ? 1'b0 : booth_sum[WIDTH];
        mult_hi_nxt = {shift_top, booth_sum[WIDTH:1]};
        mult_lo_nxt = {booth_sum[0], acc_lo[WIDTH-1:1]};
    end

    // ---------------- restoring divide step ----------------
    // remainder < |B| always, so the shifted value minus |B| fits WIDTH+1 bits signed.
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_take;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;

    always_comb begin
        div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_b};
        div_take  = ~div_diff[WIDTH];
        rem_nxt   = div_take ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        quo_nxt   = {acc_lo[WIDTH-2:0], div_take};
    end

    // ---------------- sign correction ----------------
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    always_comb begin
        quo_fix = acc_lo;
        rem_fix = acc_hi[WIDTH-1:0];
        if (!op_unsigned && (sign_a ^ sign_b)) begin
            quo_fix = -acc_lo;
        end
        if (!op_unsigned && sign_a) begin
            rem_fix = -acc_hi[WIDTH-1:0];
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            count       <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            q_m1        <= 1'b0;
            opnd_b      <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            op_unsigned <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        count       <= CW'(WIDTH);
                        op_unsigned <= start_unsigned;
                        sign_a      <= bus.a_in[WIDTH-1] & ~start_unsigned;
                        sign_b      <= bus.b_in[WIDTH-1] & ~start_unsigned;
                        q_m1        <= 1'b0;
                        acc_hi      <= '0;
                        if (!bus.op) begin
                            acc_lo <= bus.a_in;
                            opnd_b <= bus.b_in;
                        end else begin
                            acc_lo <= mag_a;
                            opnd_b <= mag_b;
                        end
                    end
                end
                MULT: begin
                    acc_hi <= mult_hi_nxt;
                    acc_lo <= mult_lo_nxt;
                    q_m1   <= acc_lo[0];
                    count  <= count - CW'(1);
                    if (count == CW'(1)) begin
                        hi_reg <= mult_hi_nxt[WIDTH-1:0];
                        lo_reg <= mult_lo_nxt;
                    end
                end
                DIV: begin
                    acc_hi <= {1'b0, rem_nxt};
                    acc_lo <= quo_nxt;
                    count  <= count - CW'(1);
                end
                FIX: begin
                    hi_reg <= rem_fix;
                    lo_reg <= quo_fix;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.div_zero  = div_zero;
    assign bus.hi        = hi_reg;
    assign bus.lo        = lo_reg;
    assign bus.state_out = state;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed bench for mult_div_ctrl: vector table of mult/div cases plus hand sequences
// for ignored starts, start in DONE and reset mid-operation. MULTDIV_UNSIGNED_EN adds multu/divu rows.
module tb_mult_div_ctrl;

    localparam int WIDTH = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    mult_div_ctrl_if #(.WIDTH(WIDTH)) bus ();

    mult_div_ctrl #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic        op;
        logic        us;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic op, input logic us,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] hi, input logic [31:0] lo,
                           input logic dz, input int lat);
        vec_t v;
        v.name = name; v.op = op; v.us = us; v.a = a; v.b = b;
        v.hi = hi; v.lo = lo; v.dz = dz; v.lat = lat;
        vecs.push_back(v);
    endtask

    task automatic drive_start(input logic op, input logic us, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a_in  = a;
        bus.b_in  = b;
`ifdef MULTDIV_UNSIGNED_EN
        bus.is_unsigned = us;
`endif
        if (us) begin
        end
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.a_in  = ~a;
        bus.b_in  = b ^ 32'h5A5A_0F0F;
    endtask

    task automatic run_op(input vec_t v);
        int   cyc;
        logic busy_ok;
        drive_start(v.op, v.us, v.a, v.b);
        cyc     = 1;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && cyc < 100) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clock);
            #1;
            cyc++;
        end
        check($sformatf("%s latency", v.name), 32'(cyc), 32'(v.lat));
        check($sformatf("%s hi", v.name), bus.hi, v.hi);
        check($sformatf("%s lo", v.name), bus.lo, v.lo);
        check($sformatf("%s div_zero", v.name), {31'd0, bus.div_zero}, {31'd0, v.dz});
        check($sformatf("%s busy_in_done", v.name), {31'd0, bus.busy}, 32'd0);
        check($sformatf("%s busy_while_running", v.name), {31'd0, busy_ok}, 32'd1);
        @(posedge clock);
        #1;
        check($sformatf("%s done_width", v.name), {31'd0, bus.done}, 32'd0);
        check($sformatf("%s back_idle", v.name), {29'd0, bus.state_out}, 32'd0);
        check($sformatf("%s hi_hold", v.name), bus.hi, v.hi);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        int          ndone;
        int          ndz;
        int          done_at;
        logic [31:0] hi_c;
        logic [31:0] lo_c;
        logic [2:0]  st_after;

        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
`ifdef MULTDIV_UNSIGNED_EN
        bus.is_unsigned = 1'b0;
`endif
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("reset state", {29'd0, bus.state_out}, 32'd0);
        check("reset hi", bus.hi, 32'd0);
        check("reset lo", bus.lo, 32'd0);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        add_vec("mult 7x-3",        0, 0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 33);
        add_vec("mult max_pos_sq",  0, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 0, 33);
        add_vec("mult min_neg_sq",  0, 0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0, 33);
        add_vec("mult -1x-1",       0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 0, 33);
        add_vec("mult 2^16x2^16",   0, 0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 0, 33);
        add_vec("mult x0",          0, 0, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 33);
        add_vec("div -7/2",         1, 0, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 34);
        add_vec("div minint/-1",    1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, 34);
        add_vec("div 100/7",        1, 0, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 0, 34);
        add_vec("div 7/-2",         1, 0, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0, 34);
        add_vec("div -100/-7",      1, 0, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E, 0, 34);
        add_vec("div 5/10",         1, 0, 32'h0000_0005, 32'h0000_000A, 32'h0000_0005, 32'h0000_0000, 0, 34);
`ifdef MULTDIV_UNSIGNED_EN
        add_vec("divu ffffffff/2",  1, 1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFF, 0, 34);
        add_vec("multu ffffffffx2", 0, 1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 0, 33);
`endif
        add_vec("div 0x2211/0x100", 1, 0, 32'h0000_2211, 32'h0000_0100, 32'h0000_0011, 32'h0000_0022, 0, 34);
        add_vec("div 100/0",        1, 0, 32'h0000_0064, 32'h0000_0000, 32'h0000_0011, 32'h0000_0022, 1, 1);

        foreach (vecs[i]) run_op(vecs[i]);

        // start pulsed while busy at cycle 5, and again while in DONE: both ignored
        drive_start(1'b0, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        cyc = 1; ndone = 0; ndz = 0; done_at = 0;
        hi_c = '0; lo_c = '0; st_after = 3'd7;
        while (cyc <= 40) begin
            if (bus.div_zero === 1'b1) ndz++;
            if (cyc == done_at + 1 && done_at != 0) st_after = bus.state_out;
            if (bus.done === 1'b1) begin
                ndone++;
                if (done_at == 0) begin
                    done_at   = cyc;
                    hi_c      = bus.hi;
                    lo_c      = bus.lo;
                    bus.start = 1'b1;
                    bus.op    = 1'b1;
                    bus.b_in  = '0;
                end else begin
                    bus.start = 1'b0;
                end
            end else if (cyc == 5) begin
                bus.start = 1'b1;
                bus.op    = 1'b1;
                bus.b_in  = '0;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clock);
            #1;
            cyc++;
        end
        bus.start = 1'b0;
        check("ignored start done count", 32'(ndone), 32'd1);
        check("ignored start done cycle", 32'(done_at), 32'd33);
        check("ignored start hi", hi_c, 32'h3FFF_FFFF);
        check("ignored start lo", lo_c, 32'h0000_0001);
        check("ignored start div_zero count", 32'(ndz), 32'd0);
        check("start in DONE ignored state", {29'd0, st_after}, 32'd0);

        // reset at cycle 10 of a mult
        drive_start(1'b0, 1'b0, 32'h0000_1234, 32'h0000_5678);
        cyc = 1;
        while (cyc < 10) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("midop reset state", {29'd0, bus.state_out}, 32'd0);
        check("midop reset busy", {31'd0, bus.busy}, 32'd0);
        check("midop reset hi", bus.hi, 32'd0);
        check("midop reset lo", bus.lo, 32'd0);
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.done === 1'b1) ndone++;
            @(posedge clock);
            #1;
        end
        check("midop reset no done", 32'(ndone), 32'd0);

        begin
            vec_t v;
            v.name = "mult after reset"; v.op = 1'b0; v.us = 1'b0;
            v.a = 32'h0000_1234; v.b = 32'h0000_5678;
            v.hi = 32'h0000_0000; v.lo = 32'h0626_0060; v.dz = 1'b0; v.lat = 33;
            run_op(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
